mdu_unit: RTL

- Multi-cycle multiply/divide unit in the E stage; it is the responder for the start/op request issued by the instruction decoder.
- Owns the HI/LO architectural registers. Executes MULT/MULTU/DIV/DIVU with fixed latency and MTHI/MTLO in a single cycle.
- Provides HI/LO read data for MFHI/MFLO.
- Exports busy; the hazard unit uses it to stall MDU-class instructions in D.

---
 rtl/mdu_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- multi-cycle multiply/divide unit for the E stage.
//
// Owns the HI/LO architectural registers. MULT/MULTU/DIV/DIVU are accepted in
// IDLE, their 64-bit result is captured into pending registers at the accept
// edge, and HI/LO are committed after a fixed busy period (MULT_CYCLES or
// DIV_CYCLES). MTHI/MTLO write HI/LO directly in one cycle. Divide by zero
// runs the full busy period but leaves HI/LO untouched.
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   E-stage instruction requests an MDU operation
//   op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs_data  in  32   operand A / MTHI-MTLO source
//   rt_data  in  32   operand B
//   cancel   in   1   exception on the E-stage instruction; blocks acceptance
//   rd_sel   in   1   read select: 0 LO, 1 HI
//   busy     out  1   calculation in progress
//   rd_data  out 32   rd_sel ? hi : lo (combinational from registers)
//   hi       out 32   HI register
//   lo       out 32   LO register
// -----------------------------------------------------------------------------
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cancel,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    state_e             state, next_state;
    logic [CNT_W-1:0]   count, next_count;
    logic [31:0]        next_hi, next_lo;
    logic [31:0]        pend_hi, pend_lo, next_pend_hi, next_pend_lo;
    logic               skip_commit, next_skip_commit;
    logic               accept;

    // ------------------------------------------------------------------
    // Datapath: result computed combinationally from the operands present
    // at the accept edge; the busy period only models pipeline latency.
    // ------------------------------------------------------------------
    logic        is_signed;
    logic [63:0] a_ext, b_ext, product;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    // Sign- or zero-extending to 64 bits lets one unsigned multiply serve
    // both MULT and MULTU; the low 64 bits of the product are exact.
    assign a_ext   = is_signed ? {{32{rs_data[31]}}, rs_data} : {32'b0, rs_data};
    assign b_ext   = is_signed ? {{32{rt_data[31]}}, rt_data} : {32'b0, rt_data};
    assign product = a_ext * b_ext;

    // Signed divide via magnitudes: quotient negative when signs differ,
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally
    // as lo=0x80000000, hi=0.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quotient, remainder;

    assign a_neg     = is_signed & rs_data[31];
    assign b_neg     = is_signed & rt_data[31];
    assign a_mag     = a_neg ? (32'd0 - rs_data) : rs_data;
    assign b_mag     = b_neg ? (32'd0 - rt_data) : rt_data;
    // Divisor forced non-zero so the divider never sees /0; the result is
    // discarded in that case anyway.
    assign b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag     = a_mag / b_safe;
    assign r_mag     = a_mag % b_safe;
    assign quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign remainder = a_neg ? (32'd0 - r_mag) : r_mag;

    assign accept = start & ~cancel & (state == IDLE);

    // ------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a hold default first so no path through the
        // case statements leaves a variable unassigned (which would infer a latch).
        next_state       = state;
        next_count       = count;
        next_hi          = hi;
        next_lo          = lo;
        next_pend_hi     = pend_hi;
        next_pend_lo     = pend_lo;
        next_skip_commit = skip_commit;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            next_pend_hi     = product[63:32];
                            next_pend_lo     = product[31:0];
                            next_skip_commit = 1'b0;
                            next_count       = CNT_W'(MULT_CYCLES);
                            next_state       = CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            next_pend_hi     = remainder;
                            next_pend_lo     = quotient;
                            next_skip_commit = (rt_data == 32'd0);
                            next_count       = CNT_W'(DIV_CYCLES);
                            next_state       = CALC;
                        end
                        OP_MTHI: next_hi = rs_data;
                        OP_MTLO: next_lo = rs_data;
                        default: ;  // 6/7: no-op
                    endcase
                end
            end

            CALC: begin
                // cancel is deliberately ignored here: it only gates acceptance.
                if (count == CNT_W'(1)) begin
                    if (!skip_commit) begin
                        next_hi = pend_hi;
                        next_lo = pend_lo;
                    end
                    next_count = '0;
                    next_state = IDLE;
                end else begin
                    next_count = count - CNT_W'(1);
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            pend_hi     <= '0;
            pend_lo     <= '0;
            skip_commit <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state       <= next_state;
            count       <= next_count;
            hi          <= next_hi;
            lo          <= next_lo;
            pend_hi     <= next_pend_hi;
            pend_lo     <= next_pend_lo;
            skip_commit <= next_skip_commit;
        end
    end

    assign busy    = (state == CALC);
    assign rd_data = rd_sel ? hi : lo;

endmodule
